// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-access arbiter: FSM encoding and
// fixed addresses/data used by the watchdog kill write and aux write protection.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD     = 2'd1,
        ST_RDWAIT = 2'd2
    } arb_state_t;

    localparam logic [5:0] BCAST_ALL_ADDR = 6'h01;
    localparam logic [7:0] KILL_DATA      = 8'h00;
    localparam logic [5:0] PROT_ADDR_MAX  = 6'h03;

endpackage

// File: rtl/reg_arb_watchdog.sv
// SPI-activity watchdog: arms on the first SPI write, counts down between SPI
// writes and requests a one-shot kill write when the count runs out.
module reg_arb_watchdog #(
    parameter int WD_W = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            wd_enable,
    input  logic [WD_W-1:0] wd_timeout,
    input  logic            spi_wack,
    input  logic            kill_grant,
    output logic            kill_pending,
    output logic            wd_tripped
);

    logic [WD_W-1:0] count;
    logic            armed;
    logic            running;
    logic            expire;

    assign running = wd_enable && (wd_timeout != '0);
    // A reload in the same cycle always beats an expiry.
    assign expire  = armed && running && !wd_tripped && !spi_wack && (count == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count        <= '0;
            armed        <= 1'b0;
            kill_pending <= 1'b0;
            wd_tripped   <= 1'b0;
        end else begin
            if (spi_wack)
                armed <= 1'b1;

            if (spi_wack || !running)
                count <= wd_timeout;
            else if (count != '0)
                count <= count - 1'b1;

            if (kill_grant)
                kill_pending <= 1'b0;
            else if (expire)
                kill_pending <= 1'b1;

            if (kill_grant)
                wd_tripped <= 1'b1;
            else if (spi_wack)
                wd_tripped <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Arbitrates SPI and internal (aux) requesters onto a single register-file
// port; a watchdog kill write preempts both when SPI goes silent.
//
//   state     | meaning
//   ST_IDLE   | accept watchdog kill or a spi/aux request; writes finish here
//   ST_RD     | rf_read_en strobe cycle
//   ST_RDWAIT | register file returns data; ack the reader at the next edge
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int WD_W   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              spi_req,
    input  logic              spi_we,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic              spi_ack,
    output logic [DATA_W-1:0] spi_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_ack,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_err,
    input  logic              wd_enable,
    input  logic [WD_W-1:0]   wd_timeout,
    output logic              wd_tripped,
    output logic [ADDR_W-1:0] rf_address,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              rf_write_en,
    output logic              rf_read_en,
    input  logic [DATA_W-1:0] rf_rd_data
);

    arb_state_t        state, state_nxt;
    logic              last_spi, last_spi_nxt;
    logic              rd_spi, rd_spi_nxt;
    logic              spi_wack, spi_wack_nxt;
    logic              spi_ack_nxt, aux_ack_nxt, aux_err_nxt;
    logic [DATA_W-1:0] spi_rdata_nxt, aux_rdata_nxt;
    logic [ADDR_W-1:0] rf_address_nxt;
    logic [DATA_W-1:0] rf_wr_data_nxt;
    logic              rf_write_en_nxt, rf_read_en_nxt;
    logic              kill_grant, kill_pending;
    logic              spi_ok, aux_ok, grant_spi, grant_aux;

    reg_arb_watchdog #(.WD_W(WD_W)) u_watchdog (
        .clock        (clock),
        .reset_n      (reset_n),
        .wd_enable    (wd_enable),
        .wd_timeout   (wd_timeout),
        .spi_wack     (spi_wack),
        .kill_grant   (kill_grant),
        .kill_pending (kill_pending),
        .wd_tripped   (wd_tripped)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            last_spi    <= 1'b0;
            rd_spi      <= 1'b0;
            spi_wack    <= 1'b0;
            spi_ack     <= 1'b0;
            aux_ack     <= 1'b0;
            aux_err     <= 1'b0;
            spi_rdata   <= '0;
            aux_rdata   <= '0;
            rf_address  <= '0;
            rf_wr_data  <= '0;
            rf_write_en <= 1'b0;
            rf_read_en  <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_spi    <= last_spi_nxt;
            rd_spi      <= rd_spi_nxt;
            spi_wack    <= spi_wack_nxt;
            spi_ack     <= spi_ack_nxt;
            aux_ack     <= aux_ack_nxt;
            aux_err     <= aux_err_nxt;
            spi_rdata   <= spi_rdata_nxt;
            aux_rdata   <= aux_rdata_nxt;
            rf_address  <= rf_address_nxt;
            rf_wr_data  <= rf_wr_data_nxt;
            rf_write_en <= rf_write_en_nxt;
            rf_read_en  <= rf_read_en_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        last_spi_nxt    = last_spi;
        rd_spi_nxt      = rd_spi;
        spi_wack_nxt    = 1'b0;
        spi_ack_nxt     = 1'b0;
        aux_ack_nxt     = 1'b0;
        aux_err_nxt     = 1'b0;
        spi_rdata_nxt   = spi_rdata;
        aux_rdata_nxt   = aux_rdata;
        rf_address_nxt  = rf_address;
        rf_wr_data_nxt  = rf_wr_data;
        rf_write_en_nxt = 1'b0;
        rf_read_en_nxt  = 1'b0;
        kill_grant      = 1'b0;

        // A requester being acked this cycle is still holding its old request.
        spi_ok    = spi_req && !spi_ack;
        aux_ok    = aux_req && !aux_ack;
        grant_spi = spi_ok && (!aux_ok || !last_spi);
        grant_aux = aux_ok && !grant_spi;

        case (state)
            ST_IDLE: begin
                if (kill_pending) begin
                    kill_grant      = 1'b1;
                    rf_write_en_nxt = 1'b1;
                    rf_address_nxt  = ADDR_W'(BCAST_ALL_ADDR);
                    rf_wr_data_nxt  = DATA_W'(KILL_DATA);
                end else if (grant_spi) begin
                    last_spi_nxt   = 1'b1;
                    rf_address_nxt = spi_addr;
                    if (spi_we) begin
                        rf_write_en_nxt = 1'b1;
                        rf_wr_data_nxt  = spi_wdata;
                        spi_ack_nxt     = 1'b1;
                        spi_wack_nxt    = 1'b1;
                    end else begin
                        rf_read_en_nxt = 1'b1;
                        rd_spi_nxt     = 1'b1;
                        state_nxt      = ST_RD;
                    end
                end else if (grant_aux) begin
                    last_spi_nxt = 1'b0;
                    if (aux_we && (aux_addr <= ADDR_W'(PROT_ADDR_MAX))) begin
                        aux_ack_nxt = 1'b1;
                        aux_err_nxt = 1'b1;
                    end else if (aux_we) begin
                        rf_address_nxt  = aux_addr;
                        rf_write_en_nxt = 1'b1;
                        rf_wr_data_nxt  = aux_wdata;
                        aux_ack_nxt     = 1'b1;
                    end else begin
                        rf_address_nxt = aux_addr;
                        rf_read_en_nxt = 1'b1;
                        rd_spi_nxt     = 1'b0;
                        state_nxt      = ST_RD;
                    end
                end
            end
            ST_RD: state_nxt = ST_RDWAIT;
            ST_RDWAIT: begin
                state_nxt = ST_IDLE;
                if (rd_spi) begin
                    spi_ack_nxt   = 1'b1;
                    spi_rdata_nxt = rf_rd_data;
                end else begin
                    aux_ack_nxt   = 1'b1;
                    aux_rdata_nxt = rf_rd_data;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a cycle-level transaction model
// and a register-file responder.
module tb_reg_access_arbiter;

    logic       clock;
    logic       reset_n;
    logic       spi_req, spi_we, aux_req, aux_we;
    logic [5:0] spi_addr, aux_addr;
    logic [7:0] spi_wdata, aux_wdata;
    logic       spi_ack, aux_ack, aux_err;
    logic [7:0] spi_rdata, aux_rdata;
    logic       wd_enable;
    logic [15:0] wd_timeout;
    logic       wd_tripped;
    logic [5:0] rf_address;
    logic [7:0] rf_wr_data, rf_rd_data;
    logic       rf_write_en, rf_read_en;

    int tests = 0;
    int fails = 0;
    bit mon_on = 0;

    reg_access_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_ack(spi_ack), .spi_rdata(spi_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_ack(aux_ack), .aux_rdata(aux_rdata), .aux_err(aux_err),
        .wd_enable(wd_enable), .wd_timeout(wd_timeout), .wd_tripped(wd_tripped),
        .rf_address(rf_address), .rf_wr_data(rf_wr_data),
        .rf_write_en(rf_write_en), .rf_read_en(rf_read_en), .rf_rd_data(rf_rd_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // register-file responder: registered read data, one cycle after the strobe
    logic [7:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        rf_rd_data = 8'h00;
    end
    always @(posedge clock) begin
        if (rf_write_en) mem[rf_address] <= rf_wr_data;
        if (rf_read_en)  rf_rd_data <= mem[rf_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // rd_left counts the cycles still owed to an in-flight read (2 = strobe
    // cycle, 1 = data-return cycle); the port is free only when it is 0.
    int         rd_left = 0;
    bit         rd_for_spi = 0;
    bit         spi_had_last = 0;
    bit         m_wack = 0;
    int         wd_cnt = 0;
    bit         wd_armed = 0, wd_pend = 0, wd_trip = 0;
    logic       e_spi_ack = 0, e_aux_ack = 0, e_aux_err = 0, e_we = 0, e_re = 0;
    logic [7:0] e_spi_rdata = 0, e_aux_rdata = 0, e_wdata = 0;
    logic [5:0] e_addr = 0;

    task automatic model_reset();
        rd_left = 0; rd_for_spi = 0; spi_had_last = 0; m_wack = 0;
        wd_cnt = 0; wd_armed = 0; wd_pend = 0; wd_trip = 0;
        e_spi_ack = 0; e_aux_ack = 0; e_aux_err = 0; e_we = 0; e_re = 0;
        e_spi_rdata = 0; e_aux_rdata = 0; e_wdata = 0; e_addr = 0;
    endtask

    task automatic model_step();
        bit spi_ok, aux_ok, go_spi, kill, wack, running, expire;
        logic [7:0] rd_sample;
        rd_sample = rf_rd_data;
        wack   = m_wack;
        spi_ok = spi_req && !e_spi_ack;
        aux_ok = aux_req && !e_aux_ack;
        running = wd_enable && (wd_timeout != 0);
        expire  = wd_armed && running && !wd_trip && !wack && (wd_cnt == 0);
        kill = 0;
        e_spi_ack = 0; e_aux_ack = 0; e_aux_err = 0; e_we = 0; e_re = 0; m_wack = 0;

        if (rd_left == 2) rd_left = 1;
        else if (rd_left == 1) begin
            rd_left = 0;
            if (rd_for_spi) begin e_spi_ack = 1; e_spi_rdata = rd_sample; end
            else begin e_aux_ack = 1; e_aux_rdata = rd_sample; end
        end else if (wd_pend) begin
            kill = 1; e_we = 1; e_addr = 6'h01; e_wdata = 8'h00;
        end else if (spi_ok || aux_ok) begin
            go_spi = spi_ok && !(aux_ok && spi_had_last);
            spi_had_last = go_spi;
            if (go_spi) begin
                e_addr = spi_addr;
                if (spi_we) begin e_we = 1; e_wdata = spi_wdata; e_spi_ack = 1; m_wack = 1; end
                else begin e_re = 1; rd_left = 2; rd_for_spi = 1; end
            end else if (aux_we && aux_addr <= 6'h03) begin
                e_aux_ack = 1; e_aux_err = 1;
            end else begin
                e_addr = aux_addr;
                if (aux_we) begin e_we = 1; e_wdata = aux_wdata; e_aux_ack = 1; end
                else begin e_re = 1; rd_left = 2; rd_for_spi = 0; end
            end
        end

        if (wack) wd_armed = 1;
        if (wack || !running) wd_cnt = wd_timeout;
        else if (wd_cnt > 0) wd_cnt = wd_cnt - 1;
        if (kill) begin wd_pend = 0; wd_trip = 1; end
        else begin
            if (expire) wd_pend = 1;
            if (wack) wd_trip = 0;
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    always @(negedge clock) begin
        if (mon_on) begin
            check("spi_ack", spi_ack, e_spi_ack);
            check("aux_ack", aux_ack, e_aux_ack);
            check("aux_err", aux_err, e_aux_err);
            check("rf_write_en", rf_write_en, e_we);
            check("rf_read_en", rf_read_en, e_re);
            check("rf_address", rf_address, e_addr);
            check("wd_tripped", wd_tripped, wd_trip);
            if (e_we)      check("rf_wr_data", rf_wr_data, e_wdata);
            if (e_spi_ack) check("spi_rdata", spi_rdata, e_spi_rdata);
            if (e_aux_ack) check("aux_rdata", aux_rdata, e_aux_rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; spi_req = 0; aux_req = 0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic spi_op(input bit we, input logic [5:0] a, input logic [7:0] d);
        int n = 0;
        spi_req = 1; spi_we = we; spi_addr = a; spi_wdata = d;
        do begin tick(1); n++; end while (!spi_ack && n < 40);
        spi_req = 0;
        if (!spi_ack) check("spi_op_timeout", 0, 1);
    endtask

    task automatic aux_op(input bit we, input logic [5:0] a, input logic [7:0] d);
        int n = 0;
        aux_req = 1; aux_we = we; aux_addr = a; aux_wdata = d;
        do begin tick(1); n++; end while (!aux_ack && n < 40);
        aux_req = 0;
        if (!aux_ack) check("aux_op_timeout", 0, 1);
    endtask

    initial begin
        int n;
        reset_n = 1'b1;
        spi_req = 0; spi_we = 0; spi_addr = 0; spi_wdata = 0;
        aux_req = 0; aux_we = 0; aux_addr = 0; aux_wdata = 0;
        wd_enable = 0; wd_timeout = 0;
        #1 reset_n = 1'b0;
        mon_on = 1;
        tick(2);
        check("reset_spi_ack", spi_ack, 0);
        check("reset_rf_address", rf_address, 0);
        check("reset_wd_tripped", wd_tripped, 0);
        reset_n = 1'b1;
        tick(1);

        // single spi write: strobe and ack for exactly one cycle
        spi_req = 1; spi_we = 1; spi_addr = 6'h04; spi_wdata = 8'hC5;
        tick(1);
        check("wr_we_c1", rf_write_en, 1);
        check("wr_addr_c1", rf_address, 6'h04);
        check("wr_data_c1", rf_wr_data, 8'hC5);
        check("wr_ack_c1", spi_ack, 1);
        spi_req = 0;
        tick(1);
        check("wr_we_c2", rf_write_en, 0);
        check("wr_ack_c2", spi_ack, 0);
        tick(1);

        // spi read with three-cycle latency
        spi_op(1, 6'h05, 8'h9A);
        tick(1);
        spi_req = 1; spi_we = 0; spi_addr = 6'h05;
        tick(1);
        check("rd_re_c1", rf_read_en, 1);
        check("rd_ack_c1", spi_ack, 0);
        tick(1);
        check("rd_re_c2", rf_read_en, 0);
        check("rd_ack_c2", spi_ack, 0);
        tick(1);
        check("rd_ack_c3", spi_ack, 1);
        check("rd_data_c3", spi_rdata, 8'h9A);
        spi_req = 0;
        tick(2);

        // both requesters held from reset: spi first, then strict alternation
        do_reset();
        spi_req = 1; spi_we = 1; spi_addr = 6'h10; spi_wdata = 8'h11;
        aux_req = 1; aux_we = 1; aux_addr = 6'h20; aux_wdata = 8'h22;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("rr_spi_ack", spi_ack, (i % 2) == 1);
            check("rr_aux_ack", aux_ack, (i % 2) == 0);
        end
        spi_req = 0; aux_req = 0;
        tick(2);

        // protected aux write is dropped with an error; others go through
        aux_req = 1; aux_we = 1; aux_addr = 6'h02; aux_wdata = 8'hFF;
        tick(1);
        check("prot_ack", aux_ack, 1);
        check("prot_err", aux_err, 1);
        check("prot_we", rf_write_en, 0);
        aux_req = 0;
        tick(2);
        aux_req = 1; aux_we = 1; aux_addr = 6'h0C; aux_wdata = 8'h33;
        tick(1);
        check("open_ack", aux_ack, 1);
        check("open_err", aux_err, 0);
        check("open_we", rf_write_en, 1);
        check("open_addr", rf_address, 6'h0C);
        aux_req = 0;
        tick(2);

        // concurrent mixed traffic, checked by the model
        fork
            begin
                spi_op(1, 6'h20, 8'hA1); spi_op(0, 6'h20, 0);
                spi_op(0, 6'h0C, 0);     spi_op(1, 6'h30, 8'hB2);
            end
            begin
                aux_op(0, 6'h05, 0);     aux_op(1, 6'h01, 8'hEE);
                aux_op(0, 6'h02, 0);     aux_op(1, 6'h3F, 8'h44);
            end
        join
        tick(2);

        // watchdog: one spi write then silence
        wd_timeout = 16'd10;
        tick(2);
        wd_enable = 1;
        spi_req = 1; spi_we = 1; spi_addr = 6'h08; spi_wdata = 8'h5A;
        tick(1);
        check("wd_arm_ack", spi_ack, 1);
        spi_req = 0;
        n = 0;
        do begin tick(1); n++; end while (!rf_write_en && n < 40);
        check("wd_kill_delay", n, 13);
        check("wd_kill_addr", rf_address, 6'h01);
        check("wd_kill_data", rf_wr_data, 8'h00);
        check("wd_kill_trip", wd_tripped, 1);
        check("wd_kill_noack", spi_ack, 0);
        tick(3);
        check("wd_sticky", wd_tripped, 1);
        wd_enable = 0;
        spi_op(1, 6'h09, 8'h77);
        tick(1);
        check("wd_cleared", wd_tripped, 0);
        tick(2);

        // reset during a read abandons it
        spi_req = 1; spi_we = 0; spi_addr = 6'h04;
        tick(1);
        check("rst_rd_strobe", rf_read_en, 1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_re_zero", rf_read_en, 0);
        check("rst_addr_zero", rf_address, 0);
        check("rst_ack_zero", spi_ack, 0);
        spi_req = 0;
        tick(2);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("rst_no_ack", spi_ack, 0);
        end
        spi_op(0, 6'h04, 0);
        check("rst_reissue_data", spi_rdata, 8'hC5);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_access_arbiter.md
REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 Parameters (name, default, meaning), each SHALL exist as listed:
  ADDR_W, 6, register address width
  DATA_W, 8, register data width
  WD_W, 16, watchdog counter width
REQ-002 Ports (name direction width meaning), each SHALL exist as listed:
  clock  in  1  main clock; one clock domain, all logic on posedge
  reset_n  in  1  reset, asynchronous assert, active-low
  spi_req / spi_we  in  1/1  SPI-side request, 1=write 0=read
  spi_addr / spi_wdata  in  ADDR_W/DATA_W  SPI address, write data
  spi_ack  out  1  one-cycle completion pulse
  spi_rdata  out  DATA_W  read data, valid while spi_ack=1
  aux_req / aux_we / aux_addr / aux_wdata  in  1/1/ADDR_W/DATA_W  internal requester, same meaning as SPI
  aux_ack / aux_rdata  out  1/DATA_W  as SPI
  aux_err  out  1  pulse with aux_ack when aux write was dropped
  wd_enable  in  1  watchdog enable
  wd_timeout  in  WD_W  watchdog reload value, cycles; 0 = watchdog off
  wd_tripped  out  1  sticky: watchdog kill write issued
  rf_address / rf_wr_data  out  ADDR_W/DATA_W  register-file address, write data
  rf_write_en / rf_read_en  out  1/1  register-file strobes
  rf_rd_data  in  DATA_W  register-file read data, registered, valid one cycle after rf_read_en

Function
REQ-003 All outputs SHALL be registered.
REQ-004 FSM states SHALL be IDLE, RD, RDWAIT; at most one register-file access in flight.
REQ-005 IDLE grant priority SHALL be: watchdog kill > round-robin between spi and aux (last-granted loses tie).
REQ-006 A requester whose ack is high in the current cycle SHALL be ignored by IDLE that cycle; req held after ack is a new request.
REQ-007 Write grant at edge k: rf_write_en=1, rf_address, rf_wr_data and requester ack=1 all SHALL be high for exactly cycle k+1; FSM stays IDLE.
REQ-008 Read grant at edge k: rf_read_en=1 during cycle k+1 (state RD); RDWAIT during k+2; at edge k+3 rdata<=rf_rd_data, ack=1 for cycle k+3; FSM returns IDLE.
REQ-009 rf_address SHALL hold its last value when idle; strobes SHALL be 0 outside the cycles in REQ-007/008.
REQ-010 aux write with aux_addr <= 6'h03 SHALL be dropped: no rf_write_en, aux_ack=1 and aux_err=1 in the same cycle; aux reads of any address are allowed.
REQ-011 Watchdog arms on first completed spi write after reset; disarmed never trips.
REQ-012 Counter SHALL reload wd_timeout on every spi write ack, and while wd_enable=0 or wd_timeout=0; otherwise decrement by 1, saturate at 0.
REQ-013 Counter reaching 0 while armed, enabled and not tripped SHALL set kill-pending; reload in the same cycle wins (no trip).
REQ-014 Kill-pending SHALL be serviced at the next IDLE as a write of 8'h00 to 6'h01 (broadcast all PWM), timed as REQ-007 with no ack; wd_tripped sets in that cycle.
REQ-015 wd_tripped SHALL clear on the next spi write ack; counter reloads.
REQ-016 In-flight read SHALL complete before kill write is issued.

Reset
REQ-017 reset_n low SHALL immediately force: state IDLE, all outputs 0, counter 0, armed/pending/tripped 0, last-grant=aux (spi wins first tie).
REQ-018 Reset mid-access SHALL abandon the access with no ack; requesters reissue.

Structure
REQ-019 Shared package reg_arb_pkg SHALL hold FSM state encoding, BCAST_ALL_ADDR=6'h01, KILL_DATA=8'h00, PROT_ADDR_MAX=6'h03.
REQ-020 Watchdog (counter, arm, pending, tripped) SHALL be sub-module reg_arb_watchdog; arbitration/FSM stays in top.

Verification
REQ-021 spi write 6'h04/8'hC5 at edge 0 -> rf_write_en, rf_address=6'h04, rf_wr_data=8'hC5, spi_ack all high cycle 1 only.
REQ-022 spi read 6'h05, rf_rd_data=8'h9A during RDWAIT -> rf_read_en high cycle 1, spi_ack with spi_rdata=8'h9A cycle 3.
REQ-023 spi and aux writes held together from reset -> spi granted first, aux next; alternation continues.
REQ-024 aux write 6'h02/8'hFF -> no rf_write_en, aux_ack=aux_err=1 one cycle; aux write 6'h0C -> accepted, aux_err=0.
REQ-025 wd_enable=1, wd_timeout=10, one spi write then silence -> kill write 6'h01/8'h00 issued ~10 cycles after ack, wd_tripped=1; next spi write clears it.
REQ-026 reset_n low during RD -> outputs 0 immediately, no ack after release, next request served normally.
